// File: rtl/serial_avalon_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_avalon_master                                       |
// | Description : Avalon-MM master for the UP RS232 register map. Turns a    |
// |               byte-stream TX port into data-register writes and drains   |
// |               the RX FIFO into a 1-entry byte-stream RX buffer.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_avalon_master #(
  parameter int READ_LATENCY = 1,
  parameter int POLL_DIV     = 1024,
  parameter bit RX_IRQ_EN    = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_irq
);

  localparam logic [2:0] c_ST_INIT   = 3'd0;
  localparam logic [2:0] c_ST_POLL   = 3'd1;
  localparam logic [2:0] c_ST_WCTRL  = 3'd2;
  localparam logic [2:0] c_ST_DECIDE = 3'd3;
  localparam logic [2:0] c_ST_TXWR   = 3'd4;
  localparam logic [2:0] c_ST_RXRD   = 3'd5;
  localparam logic [2:0] c_ST_WDATA  = 3'd6;
  localparam logic [2:0] c_ST_IDLE   = 3'd7;

  localparam int                 c_CNT_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(POLL_DIV - 1);
  localparam logic [1:0]         c_LAT_LAST = 2'(READ_LATENCY - 1);

  logic [2:0]         r_state;
  logic               r_run;      // 0 for the first cycle after reset so no strobe leaves reset
  logic [1:0]         r_lat;
  logic [c_CNT_W-1:0] r_cnt;
  logic [15:0]        r_wspace;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;

  logic w_init_wr;
  logic w_tx_wr;
  logic w_lat_done;
  logic w_idle_exit;
  logic w_capture;
  logic w_unused_rd;

  // Decode the access of the current state and the common exit conditions
  always_comb begin
    w_init_wr   = (r_state == c_ST_INIT) && r_run;
    w_tx_wr     = (r_state == c_ST_TXWR);
    w_lat_done  = (r_lat == c_LAT_LAST);
    w_idle_exit = tx_valid || avm_irq || (r_cnt == c_CNT_LAST);
    w_capture   = (r_state == c_ST_WDATA) && w_lat_done && avm_readdata[15];
  end

  // Readdata bits 14:8 carry nothing this master needs
  assign w_unused_rd = &{1'b0, avm_readdata[14:8]};

  assign avm_write      = w_init_wr || w_tx_wr;
  assign avm_read       = (r_state == c_ST_POLL) || (r_state == c_ST_RXRD);
  assign avm_address    = w_init_wr || (r_state == c_ST_POLL);
  assign avm_chipselect = avm_write || avm_read;
  assign avm_byteenable = 4'hF;
  assign avm_writedata  = w_init_wr ? {30'b0, 1'b0, RX_IRQ_EN} :
                          (w_tx_wr ? {24'b0, tx_data} : 32'b0);
  assign tx_ready       = w_tx_wr;
  assign rx_data        = r_rx_data;
  assign rx_valid       = r_rx_valid;

  // Access sequencer: init, status polling, TX bursts on cached space, RX draining
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state  <= c_ST_INIT;
      r_run    <= 1'b0;
      r_lat    <= 2'd0;
      r_cnt    <= '0;
      r_wspace <= 16'd0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          r_run <= 1'b1;
          if (r_run) r_state <= c_ST_POLL;
        end
        c_ST_POLL: r_state <= c_ST_WCTRL;
        c_ST_WCTRL: begin
          if (w_lat_done) begin
            r_lat    <= 2'd0;
            r_wspace <= avm_readdata[31:16];
            r_state  <= c_ST_DECIDE;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        c_ST_DECIDE: begin
          if (tx_valid && (r_wspace != 16'd0)) r_state <= c_ST_TXWR;
          else if (!r_rx_valid)                r_state <= c_ST_RXRD;
          else                                 r_state <= c_ST_IDLE;
        end
        c_ST_TXWR: begin
          if (r_wspace != 16'd0) r_wspace <= r_wspace - 16'd1;
          r_state <= c_ST_DECIDE;
        end
        c_ST_RXRD: r_state <= c_ST_WDATA;
        c_ST_WDATA: begin
          if (w_lat_done) begin
            r_lat   <= 2'd0;
            r_state <= avm_readdata[15] ? c_ST_DECIDE : c_ST_IDLE;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        c_ST_IDLE: begin
          if (w_idle_exit) begin
            r_cnt   <= '0;
            r_state <= c_ST_POLL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= c_ST_INIT;
      endcase
    end
  end

  // One-entry RX buffer: filled only when empty, emptied by the consumer handshake
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
    end else begin
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (w_capture) begin
        r_rx_data  <= avm_readdata[7:0];
        r_rx_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_avalon_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_avalon_master                                    |
// | Description : Bench for serial_avalon_master with a UP RS232 slave model |
// |               and byte-order scoreboards for both directions.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_avalon_master;

  localparam int RL = 2;
  localparam int PD = 16;

  logic        clk_clk      = 1'b0;
  logic        reset_reset  = 1'b1;
  logic [7:0]  tx_data      = 8'h00;
  logic        tx_valid     = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready     = 1'b0;
  logic        avm_address;
  logic        avm_chipselect;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_irq      = 1'b0;

  always #5 clk_clk = ~clk_clk;

  serial_avalon_master #(
    .READ_LATENCY (RL),
    .POLL_DIV     (PD),
    .RX_IRQ_EN    (1'b1)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_byteenable (avm_byteenable),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_irq        (avm_irq)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Slave model state and scoreboards
  int          sl_wspace = 0;
  logic        sl_re     = 1'b0;
  logic [7:0]  sl_rx[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_q[$];
  logic [31:0] rpipe[$];
  int          acc_kind[$];   // 0 ctrl wr, 1 ctrl rd, 2 data wr, 3 data rd
  int          wr_cyc[$];
  int          n_kind[4] = '{default: 0};
  int          prev_poll = 0;
  int          last_poll = 0;
  int          last_rd   = -100;
  int          n_tx_acc  = 0;
  int          n_tx_push = 0;
  int          n_rx_got  = 0;
  int          rx_mode   = 0;
  logic        prev_txr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_clk);
      #1;
      tx_valid = (tx_q.size() > 0);
      if (tx_q.size() > 0) tx_data = tx_q[0];
      else                 tx_data = 8'h00;
      case (rx_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_q.push_back(b);
    exp_tx.push_back(b);
    n_tx_push++;
  endtask

  task automatic wait_kind(input int k, input int target, input int budget, input string tag);
    int t;
    t = 0;
    while (n_kind[k] < target && t < budget) begin
      step(1);
      t++;
    end
    chk(tag, 32'(n_kind[k] >= target), 32'd1);
  endtask

  // Slave responder and protocol monitor, sampled mid-cycle
  initial begin : slave_monitor
    logic [31:0] resp;
    logic [7:0]  b;
    int          k;
    for (int i = 0; i < RL; i++) rpipe.push_back(32'h0);
    forever begin
      @(negedge clk_clk);
      cyc++;
      avm_readdata = rpipe.pop_front();
      if (reset_reset) begin
        rpipe.delete();
        for (int i = 0; i < RL; i++) rpipe.push_back(32'h0);
        avm_readdata = 32'h0;
        prev_txr     = 1'b0;
        last_rd      = -100;
      end else begin
        chk("chipselect", 32'(avm_chipselect), 32'(avm_read | avm_write));
        chk("byteenable", 32'(avm_byteenable), 32'hF);
        chk("rd_wr_excl", 32'(avm_read & avm_write), 32'd0);
        chk("txready_gap", 32'(prev_txr & tx_ready), 32'd0);
        chk("txready_wr", 32'(tx_ready & ~(avm_write & ~avm_address)), 32'd0);
        prev_txr = tx_ready;
        resp = 32'h0;
        if (avm_read || avm_write) begin
          chk("one_outstanding", 32'((cyc - last_rd) > RL), 32'd1);
          k = avm_read ? (avm_address ? 1 : 3) : (avm_address ? 0 : 2);
          acc_kind.push_back(k);
          n_kind[k]++;
          case (k)
            0: begin
              chk("ctrl_wr_data", avm_writedata, 32'h1);
              sl_re = avm_writedata[0];
            end
            1: begin
              prev_poll = last_poll;
              last_poll = cyc;
              last_rd   = cyc;
              resp = {16'(sl_wspace), 14'h0, 1'b0, sl_re};
            end
            2: begin
              wr_cyc.push_back(cyc);
              chk("wr_with_space", 32'(sl_wspace > 0), 32'd1);
              if (sl_wspace > 0) sl_wspace--;
              chk("wr_expected", 32'(exp_tx.size() > 0), 32'd1);
              if (exp_tx.size() > 0) begin
                b = exp_tx.pop_front();
                chk("wr_byte", avm_writedata, {24'h0, b});
              end
            end
            default: begin
              last_rd = cyc;
              chk("rd_while_held", 32'(rx_valid), 32'd0);
              if (sl_rx.size() > 0) begin
                resp = {16'(sl_rx.size()), 1'b1, 7'h0, sl_rx[0]};
                b = sl_rx.pop_front();
                exp_rx.push_back(b);
              end else begin
                resp = $urandom & 32'hFFFF_7FFF;
              end
            end
          endcase
        end
        rpipe.push_back(resp);
        if (tx_ready && tx_valid) begin
          n_tx_acc++;
          if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        if (rx_valid && rx_ready) begin
          n_rx_got++;
          chk("rx_expected", 32'(exp_rx.size() > 0), 32'd1);
          if (exp_rx.size() > 0) begin
            b = exp_rx.pop_front();
            chk("rx_byte", 32'(rx_data), 32'(b));
          end
        end
      end
    end
  end

  // Directed sequence followed by a randomized soak and drain
  initial begin : main
    int   n1, n2, n3, a, g, base, first, t;
    logic seen;

    // Reset values
    reset_reset = 1'b1;
    step(3);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    chk("rst_be", 32'(avm_byteenable), 32'hF);
    chk("rst_txready", 32'(tx_ready), 32'd0);
    chk("rst_rxvalid", 32'(rx_valid), 32'd0);
    chk("rst_rxdata", 32'(rx_data), 32'd0);
    reset_reset = 1'b0;
    wait_kind(0, 1, 10, "init_wr_timeout");
    if (acc_kind.size() > 0) chk("first_access_ctrl_wr", 32'(acc_kind[0]), 32'd0);

    // TX burst on cached space
    sl_wspace = 'h80;
    step(3 * PD + 30);
    n1 = n_kind[1];
    n2 = n_kind[2];
    a  = n_tx_acc;
    push_tx(8'h41);
    push_tx(8'h42);
    push_tx(8'h43);
    wait_kind(2, n2 + 3, 100, "tx3_timeout");
    chk("tx3_polls_le1", 32'((n_kind[1] - n1) <= 1), 32'd1);
    chk("tx3_ready_pulses", 32'(n_tx_acc - a), 32'd3);
    if (wr_cyc.size() >= 3) chk("tx_burst_gap", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-3]), 32'd4);

    // Reset in the middle of a data write
    push_tx(8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      seen = tx_ready;
    end
    chk("txwr_seen", 32'(seen), 32'd1);
    reset_reset = 1'b1;
    step(1);
    chk("midrst_write", 32'(avm_write), 32'd0);
    chk("midrst_read", 32'(avm_read), 32'd0);
    chk("midrst_cs", 32'(avm_chipselect), 32'd0);
    chk("midrst_txready", 32'(tx_ready), 32'd0);
    base = acc_kind.size();
    reset_reset = 1'b0;
    t = 0;
    while (acc_kind.size() <= base && t < 10) begin
      step(1);
      t++;
    end
    chk("postrst_access_timeout", 32'(acc_kind.size() > base), 32'd1);
    if (acc_kind.size() > base) chk("postrst_first_ctrl_wr", 32'(acc_kind[base]), 32'd0);
    wait_kind(2, n_kind[2] + 1, 100, "postrst_tx_timeout");

    // TX with no space, then a single slot
    sl_wspace = 0;
    step(3 * PD + 40);
    n1 = n_kind[1];
    n2 = n_kind[2];
    a  = n_tx_acc;
    push_tx(8'h77);
    push_tx(8'h78);
    step(60);
    chk("full_no_write", 32'(n_kind[2] - n2), 32'd0);
    chk("full_no_ready", 32'(n_tx_acc - a), 32'd0);
    chk("full_repoll", 32'(n_kind[1] > n1), 32'd1);
    sl_wspace = 1;
    step(60);
    chk("one_space_one_write", 32'(n_kind[2] - n2), 32'd1);
    if (wr_cyc.size() > 0) chk("one_space_repoll", 32'(last_poll > wr_cyc[wr_cyc.size()-1]), 32'd1);
    sl_wspace = 8;
    wait_kind(2, n2 + 2, 100, "tx_resume_timeout");

    // RX capture held until consumed
    rx_mode = 0;
    sl_rx.push_back(8'h55);
    t = 0;
    while (!rx_valid && t < 100) begin
      step(1);
      t++;
    end
    chk("rx_cap_timeout", 32'(rx_valid), 32'd1);
    chk("rx_data_55", 32'(rx_data), 32'h55);
    n3 = n_kind[3];
    step(3 * PD + 10);
    chk("rx_held_valid", 32'(rx_valid), 32'd1);
    chk("rx_held_data", 32'(rx_data), 32'h55);
    chk("no_rd_while_held", 32'(n_kind[3] - n3), 32'd0);
    chk("poll_gap_held", 32'(last_poll - prev_poll), 32'(RL + PD + 2));
    g = n_rx_got;
    rx_mode = 1;
    step(1);
    rx_mode = 0;
    step(2);
    chk("rx_released", 32'(rx_valid), 32'd0);
    chk("rx_got_one", 32'(n_rx_got - g), 32'd1);

    // RX empty: idle polling, then interrupt-driven polling
    sl_wspace = 4;
    g = n_rx_got;
    step(3 * (PD + 2 * RL + 3) + 10);
    chk("poll_gap_empty", 32'(last_poll - prev_poll), 32'(2 * RL + 3 + PD));
    chk("rx_empty_valid", 32'(rx_valid), 32'd0);
    avm_irq = 1'b1;
    step(40);
    chk("poll_gap_irq", 32'(last_poll - prev_poll), 32'(2 * RL + 4));
    avm_irq = 1'b0;
    step(30);
    chk("rx_empty_none_got", 32'(n_rx_got - g), 32'd0);

    // TX has priority over pending RX data
    n3 = n_kind[3];
    t = 0;
    while (n_kind[3] <= n3 && t < 60) begin
      step(1);
      t++;
    end
    chk("contention_sync_timeout", 32'(n_kind[3] > n3), 32'd1);
    step(RL + 2);
    base = acc_kind.size();
    sl_rx.push_back(8'hA1);
    push_tx(8'hB2);
    rx_mode = 1;
    step(60);
    first = -1;
    for (int i = base; i < acc_kind.size(); i++)
      if (first < 0 && (acc_kind[i] == 2 || acc_kind[i] == 3)) first = acc_kind[i];
    chk("tx_before_rx", 32'(first), 32'd2);
    chk("contention_rx_drained", 32'(exp_rx.size() + sl_rx.size()), 32'd0);

    // Randomized soak
    rx_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0 && tx_q.size() < 4) push_tx(8'($urandom));
      if ($urandom_range(0, 19) == 0) sl_rx.push_back(8'($urandom));
      if ($urandom_range(0, 9) == 0 && sl_wspace < 200) sl_wspace += int'($urandom_range(1, 3));
      avm_irq = ($urandom_range(0, 7) == 0);
      step(1);
    end

    // Drain everything
    avm_irq   = 1'b0;
    rx_mode   = 1;
    sl_wspace = sl_wspace + 64;
    t = 0;
    while ((tx_q.size() > 0 || sl_rx.size() > 0 || exp_rx.size() > 0 || rx_valid) && t < 3000) begin
      step(1);
      t++;
    end
    chk("drain_done", 32'(t < 3000), 32'd1);
    chk("tx_all_written", 32'(exp_tx.size()), 32'd0);
    chk("tx_handshakes", 32'(n_tx_acc), 32'(n_tx_push));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
